// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - two-channel stream demultiplexer with per-channel FIFOs
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sel,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out0_valid,
    output logic [WIDTH-1:0]         out0_data,
    input  logic                     out0_ready,
    output logic                     out1_valid,
    output logic [WIDTH-1:0]         out1_data,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   lvl0,
    output logic [$clog2(DEPTH):0]   lvl1,
    output logic [15:0]              cnt0,
    output logic [15:0]              cnt1
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [LW-1:0]    lvl_w  [2];
    logic [15:0]      cnt_w  [2];
    logic [WIDTH-1:0] head_w [2];
    logic [1:0]       valid_w;
    logic [1:0]       take;

    assign take = {out1_ready, out0_ready};

    // Ready looks only at the channel the current word is steered to.
    assign in_ready = in_sel ? (lvl_w[1] != FULL) : (lvl_w[0] != FULL);

    for (genvar k = 0; k < 2; k++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [LW-1:0]    lvl;
        logic [15:0]      cnt;
        logic             sel_match;
        logic             push;
        logic             pop;

        assign sel_match = (k == 0) ? ~in_sel : in_sel;
        assign push      = in_valid & in_ready & sel_match;
        assign pop       = valid_w[k] & take[k];

        assign valid_w[k] = (lvl != '0);
        assign head_w[k]  = mem[rd_ptr];
        assign lvl_w[k]   = lvl;
        assign cnt_w[k]   = cnt;

        // Storage: cleared on reset so the head word reads as zero when empty.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else if (push) begin
                mem[wr_ptr] <= in_data;
            end
        end

        // Pointers, occupancy and delivered-word counter; pointers wrap naturally.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                lvl    <= '0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    cnt    <= cnt + 16'd1;
                end
                case ({push, pop})
                    2'b10:   lvl <= lvl + LW'(1);
                    2'b01:   lvl <= lvl - LW'(1);
                    default: lvl <= lvl;
                endcase
            end
        end
    end

    assign out0_valid = valid_w[0];
    assign out1_valid = valid_w[1];
    assign out0_data  = head_w[0];
    assign out1_data  = head_w[1];
    assign lvl0       = lvl_w[0];
    assign lvl1       = lvl_w[1];
    assign cnt0       = cnt_w[0];
    assign cnt1       = cnt_w[1];

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - scoreboard bench for stream_demux
module tb_stream_demux;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out0_valid;
    logic [WIDTH-1:0] out0_data;
    logic             out0_ready;
    logic             out1_valid;
    logic [WIDTH-1:0] out1_data;
    logic             out1_ready;
    logic [2:0]       lvl0;
    logic [2:0]       lvl1;
    logic [15:0]      cnt0;
    logic [15:0]      cnt1;

    stream_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
        .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
        .lvl0(lvl0), .lvl1(lvl1), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // Reference model: one queue of expected words per channel plus delivered counts.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         exp_cnt0;
    int         exp_cnt1;
    int         total;
    int         passed;
    bit         busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare DUT outputs against the model, pop on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out0_valid", out0_valid, q0.size() != 0);
            chk("out1_valid", out1_valid, q1.size() != 0);
            chk("lvl0", lvl0, q0.size());
            chk("lvl1", lvl1, q1.size());
            chk("cnt0", cnt0, exp_cnt0 % 65536);
            chk("cnt1", cnt1, exp_cnt1 % 65536);
            chk("in_ready", in_ready, in_sel ? (q1.size() != DEPTH) : (q0.size() != DEPTH));
            if (out0_valid && out0_ready && q0.size() != 0) begin
                chk("out0_data", out0_data, q0.pop_front());
                exp_cnt0++;
            end
            if (out1_valid && out1_ready && q1.size() != 0) begin
                chk("out1_data", out1_data, q1.pop_front());
                exp_cnt1++;
            end
        end
    end

    task automatic send(input logic s, input logic [7:0] d);
        bit ok;
        ok = 0;
        in_valid = 1;
        in_sel   = s;
        in_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (in_ready) begin
                if (s) q1.push_back(d);
                else   q0.push_back(d);
                ok = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q0.size() + q1.size()) != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_left", q0.size() + q1.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_v0"}, out0_valid, 0);
        chk({tag, "_v1"}, out1_valid, 0);
        chk({tag, "_lvl0"}, lvl0, 0);
        chk({tag, "_lvl1"}, lvl1, 0);
        chk({tag, "_cnt0"}, cnt0, 0);
        chk({tag, "_cnt1"}, cnt1, 0);
        chk({tag, "_d0"}, out0_data, 0);
        chk({tag, "_d1"}, out1_data, 0);
        chk({tag, "_rdy"}, in_ready, 1);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk); #3;
        rst = 1;
        q0.delete();
        q1.delete();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        #1;
        check_reset_state(tag);
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        clk = 0; rst = 0;
        in_valid = 0; in_sel = 0; in_data = 0;
        out0_ready = 1; out1_ready = 1;
        exp_cnt0 = 0; exp_cnt1 = 0; total = 0; passed = 0; busy = 0;

        // Reset asserted between edges, checked immediately.
        #2 rst = 1;
        #1 check_reset_state("rst0");
        @(posedge clk); #1;
        rst = 0;
        idle(2);

        // Alternating route.
        send(0, 8'hA1);
        send(1, 8'hB2);
        send(0, 8'hC3);
        drain();
        idle(2);
        chk("alt_cnt0", cnt0, 2);
        chk("alt_cnt1", cnt1, 1);

        // Fill channel 0 and check back-pressure isolation.
        out0_ready = 0;
        for (int i = 0; i < 4; i++) send(0, 8'(8'h10 + i));
        @(negedge clk); #1;
        chk("fill_lvl0", lvl0, 4);
        in_sel = 0;
        #1 chk("fill_rdy_sel0", in_ready, 0);
        in_sel = 1;
        #1 chk("fill_rdy_sel1", in_ready, 1);
        @(posedge clk); #1;
        send(1, 8'h55);
        out0_ready = 1;
        @(negedge clk); #1;
        chk("unfill_lvl0_before_pop", lvl0, 4);
        @(posedge clk); #1;
        chk("unfill_rdy", in_ready | (in_sel == 1), 1);
        in_sel = 0;
        #1 chk("unfill_rdy_sel0", in_ready, 1);
        drain();

        // Simultaneous push and pop at lvl0 == 2.
        out0_ready = 0;
        send(0, 8'h20);
        send(0, 8'h21);
        out0_ready = 1;
        send(0, 8'h77);
        out0_ready = 0;
        @(negedge clk); #1;
        chk("pushpop_lvl0", lvl0, 2);
        @(posedge clk); #1;
        out0_ready = 1;
        drain();

        // Pointer wrap on channel 1 with random consumer stalls.
        reset_pulse("rst1");
        busy = 1;
        fork
            begin
                for (int i = 0; i < 10; i++) send(1, 8'(i));
                busy = 0;
            end
            begin
                while (busy) begin
                    out1_ready = 1'($urandom % 2);
                    @(posedge clk); #1;
                end
            end
        join
        out1_ready = 1;
        drain();
        idle(1);
        chk("wrap_cnt1", cnt1, 10);

        // Reset in the middle of traffic.
        out0_ready = 0; out1_ready = 0;
        send(0, 8'hE0);
        send(0, 8'hE1);
        send(0, 8'hE2);
        send(1, 8'hF0);
        @(negedge clk); #1;
        chk("mid_lvl0", lvl0, 3);
        chk("mid_lvl1", lvl1, 1);
        reset_pulse("rst2");
        out0_ready = 1; out1_ready = 1;
        idle(6);
        chk("post_rst_v0", out0_valid, 0);
        chk("post_rst_v1", out1_valid, 0);

        // Random mixed traffic on both channels.
        busy = 1;
        fork
            begin
                for (int i = 0; i < 150; i++) send(1'($urandom % 2), 8'($urandom));
                busy = 0;
            end
            begin
                while (busy) begin
                    out0_ready = 1'($urandom % 2);
                    out1_ready = 1'($urandom % 4 != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out0_ready = 1; out1_ready = 1;
        drain();
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Two-channel stream demultiplexer: the receiving-end counterpart of the team's 2:1 select mux (`z = c ? b : a`). It takes one valid/ready input stream whose words carry a select bit, and steers each word into one of two output channels. Each channel is buffered by its own FIFO, so one blocked consumer never stalls words bound for the other channel once they are accepted. The block sits between a single producer and two independent consumers, for example splitting a result bus toward two writeback paths.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 4: entries per channel FIFO; must be a power of 2 and at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the producer presents a word.
- `in_sel`  in  1  destination of the word: 0 routes to channel 0, 1 routes to channel 1.
- `in_data`  in  WIDTH  input word.
- `in_ready`  out  1  the block can accept the presented word this cycle.
- `out0_valid`, `out1_valid`  out  1  the channel FIFO is non-empty.
- `out0_data`, `out1_data`  out  WIDTH  head word of the channel FIFO.
- `out0_ready`, `out1_ready`  in  1  the consumer takes the head word.
- `lvl0`, `lvl1`  out  $clog2(DEPTH)+1  current occupancy of each channel FIFO.
- `cnt0`, `cnt1`  out  16  number of words delivered per channel; wraps modulo 2^16.

## Operation
- Each channel has:
  - a FIFO of DEPTH entries;
  - a write pointer and a read pointer, each $clog2(DEPTH) bits wide and wrapping naturally;
  - an occupancy counter `lvl`.
- `in_ready` is combinational: `in_sel ? (lvl1 != DEPTH) : (lvl0 != DEPTH)`.
  - It depends only on the selected channel.
  - The other channel's state never affects it.
- Push to channel k occurs when `in_valid & in_ready` and `in_sel == k`:
  - write `in_data` at `wr_ptr`;
  - increment `wr_ptr`.
- Pop from channel k occurs when `outk_valid & outk_ready`:
  - increment `rd_ptr`;
  - increment `cntk`.
- `outk_valid` equals `(lvlk != 0)`.
- `outk_data` equals `mem[rd_ptr]`. It is valid only while `outk_valid` is high.
- Occupancy update per channel:
  - push only: `lvl` + 1;
  - pop only: `lvl` − 1;
  - push and pop in the same cycle: `lvl` unchanged.
- Words leave each channel in the same order they entered it.
- No ordering relation holds between the two channels.
- There is no bypass path:
  - an empty FIFO never presents an input word in the same cycle it arrives;
  - a full FIFO refuses input even if a pop occurs in that cycle.
- `in_valid` with `in_ready` low is a stall. The producer must hold `in_data` and `in_sel` until accepted.
- Reset, asynchronous, taking effect immediately regardless of `clk`:
  - all pointers, `lvl0`/`lvl1` and `cnt0`/`cnt1` go to 0;
  - all FIFO storage goes to 0;
  - so `out0_valid`/`out1_valid` = 0 and `out0_data`/`out1_data` = 0.
- Reset in the middle of traffic discards every buffered word. Counters restart from 0.
- Reset value of `in_ready` is 1, since both FIFOs are empty.
- `cnt` wraps from 16'hFFFF to 16'h0000 with no saturation and no flag.
- There is no state machine beyond the per-channel pointer and counter logic. The two channels are fully independent copies.

## Timing
- Latency: a word accepted at edge N has `outk_valid` = 1 and `outk_data` = that word after edge N, i.e. in cycle N+1.
- Throughput: one word per cycle into the block, and one word per cycle out of each channel concurrently.
- `lvl`, `cnt`, `valid` and `data` are all updated on the same edge as the push or pop that changes them.
- `in_ready` reflects the current-cycle `in_sel` combinationally. There is no registered ready.
- Full boundary: at `lvl == DEPTH`, `in_ready` is 0 for that channel while the other channel stays accepting. One pop makes `in_ready` 1 in the following cycle.
- Pointer wrap: after DEPTH pushes, `wr_ptr` returns to 0. Data order must be preserved across the wrap.

## Test plan
- Reset then idle:
  - assert `rst` asynchronously between clock edges;
  - require, immediately: `out0_valid` = `out1_valid` = 0, `lvl0` = `lvl1` = 0, `cnt0` = `cnt1` = 0, data = 0 and `in_ready` = 1.
- Alternating route, both readies held 1 (WIDTH = 8, DEPTH = 4):
  - send 8'hA1 (sel 0), 8'hB2 (sel 1), 8'hC3 (sel 0);
  - require `out0` to deliver A1 then C3, and `out1` to deliver B2, each one cycle after acceptance;
  - require `cnt0` = 2 and `cnt1` = 1 at the end.
- Fill and back-pressure:
  - hold `out0_ready` = 0 and push 8'h10..8'h13 to channel 0;
  - require `lvl0` = 4 and `in_ready` = 0 for sel 0, while a sel-1 push of 8'h55 is still accepted;
  - release `out0_ready` and require 10, 11, 12, 13 delivered in order.
- Simultaneous push and pop:
  - with `lvl0` = 2, push 8'h77 and pop in the same cycle;
  - require `lvl0` to stay 2 and 8'h77 to be delivered third.
- Pointer wrap: stream 10 words 8'h00..8'h09 through channel 1 with random `out1_ready`, and require in-order delivery and `cnt1` = 10.
- Reset mid-traffic: with `lvl0` = 3 and `lvl1` = 1, pulse `rst`, and require both FIFOs to be empty, the counters to be 0, and none of the old words to appear afterwards.
